// File: rtl/mux_l2_pkg.sv
// mux_l2_pkg
// Shared definitions for the layer-2 2:1 byte multiplexer path.
// Contents:
//   DEFAULT_DATA_W     - default word width of each lane
//   DEFAULT_FIFO_DEPTH - default entries per lane FIFO (power of two, >= 2)
//   lane_e             - lane identifiers LANE0 / LANE1
//   arb_state_e        - arbiter states LAST0 / LAST1 (lane granted most recently)
package mux_l2_pkg;

  localparam int DEFAULT_DATA_W     = 8;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_sync_l2.sv
// fifo_sync_l2
// Single-clock FIFO used as the per-lane buffer of the layer-2 multiplexer.
// The head word is presented combinationally on dout, so a pop consumes the
// word that is visible in the cycle before the edge.
// Ports:
//   clk     - clock, all updates on the rising edge
//   reset_L - asynchronous active-low reset, empties the FIFO
//   push    - write din on this edge (caller only pushes when not full or popping)
//   pop     - drop the head word on this edge (caller only pops when not empty)
//   din     - word to write
//   dout    - current head word
//   count   - number of stored words, 0..DEPTH
//   full    - count == DEPTH
//   empty   - count == 0
module fifo_sync_l2 #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two. A simultaneous
  // push and pop leaves the count unchanged, which is also how a full FIFO
  // accepts a new word on the edge its head leaves.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: a word is only ever read after it was written.
  // When full and popping, the write slot equals the read slot, but the old
  // head has already been read out combinationally before the edge.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/arb_rr_mux_l2.sv
// arb_rr_mux_l2
// Two-lane round-robin arbiter and sequencer for the layer-2 2:1 byte
// multiplexer. Each lane is buffered in its own FIFO; every cycle with
// ready_out high one non-empty lane is granted and its head word is
// registered onto dataout_muxL2. When both lanes request, the lane not
// granted last time wins, so contended lanes strictly alternate.
// Ports:
//   clk, reset_L                  - clock, asynchronous active-low reset
//   valid0, data_in0_muxL2        - lane 0 input word and qualifier
//   valid1, data_in1_muxL2        - lane 1 input word and qualifier
//   ready_out                     - downstream accepts a word this cycle
//   full0, full1                  - lane FIFO holds FIFO_DEPTH words
//   ovf0, ovf1                    - sticky: a word was dropped on that lane
//   selectorL2                    - lane that sourced dataout_muxL2
//   validout                      - dataout_muxL2 carries a new word
//   dataout_muxL2                 - arbitrated word
module arb_rr_mux_l2
  import mux_l2_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              valid0,
  input  logic [DATA_W-1:0] data_in0_muxL2,
  input  logic              valid1,
  input  logic [DATA_W-1:0] data_in1_muxL2,
  input  logic              ready_out,
  output logic              full0,
  output logic              full1,
  output logic              ovf0,
  output logic              ovf1,
  output logic              selectorL2,
  output logic              validout,
  output logic [DATA_W-1:0] dataout_muxL2
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = FIFO_DEPTH[CW-1:0];

  logic [DATA_W-1:0] head0, head1;
  logic [CW-1:0]     count0, count1;
  logic              fifo_full0, fifo_full1;
  logic              empty0, empty1;
  logic              push0, push1;
  logic              pop0, pop1;

  arb_state_e state, state_next;
  logic       grant_valid;
  lane_e      grant_lane;

  fifo_sync_l2 #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk    (clk),
    .reset_L(reset_L),
    .push   (push0),
    .pop    (pop0),
    .din    (data_in0_muxL2),
    .dout   (head0),
    .count  (count0),
    .full   (fifo_full0),
    .empty  (empty0)
  );

  fifo_sync_l2 #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk    (clk),
    .reset_L(reset_L),
    .push   (push1),
    .pop    (pop1),
    .din    (data_in1_muxL2),
    .dout   (head1),
    .count  (count1),
    .full   (fifo_full1),
    .empty  (empty1)
  );

  // Arbiter state register; LAST1 out of reset so lane 0 wins the first
  // contested grant.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= LAST1;
    else          state <= state_next;
  end

  // Grant decision. Requests come only from words already stored, so a word
  // arriving this cycle cannot be granted before the next edge.
  always_comb begin
    grant_valid = 1'b0;
    grant_lane  = LANE0;
    state_next  = state;
    if (ready_out) begin
      if (!empty0 && !empty1) begin
        grant_valid = 1'b1;
        grant_lane  = (state == LAST0) ? LANE1 : LANE0;
      end else if (!empty0) begin
        grant_valid = 1'b1;
        grant_lane  = LANE0;
      end else if (!empty1) begin
        grant_valid = 1'b1;
        grant_lane  = LANE1;
      end
    end
    if (grant_valid) state_next = (grant_lane == LANE1) ? LAST1 : LAST0;
  end

  // A full lane still accepts a word on the edge its head is popped.
  assign pop0  = grant_valid && (grant_lane == LANE0);
  assign pop1  = grant_valid && (grant_lane == LANE1);
  assign push0 = valid0 && (!fifo_full0 || pop0);
  assign push1 = valid1 && (!fifo_full1 || pop1);

  assign full0 = (count0 == FULL_CNT);
  assign full1 = (count1 == FULL_CNT);

  // Output registers: data and selector hold their last value when nothing
  // is granted, only validout drops.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      validout      <= 1'b0;
      selectorL2    <= 1'b0;
      dataout_muxL2 <= '0;
    end else begin
      validout <= grant_valid;
      if (grant_valid) begin
        selectorL2    <= grant_lane;
        dataout_muxL2 <= (grant_lane == LANE1) ? head1 : head0;
      end
    end
  end

  // Overflow flags are sticky until reset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ovf0 <= 1'b0;
      ovf1 <= 1'b0;
    end else begin
      if (valid0 && !push0) ovf0 <= 1'b1;
      if (valid1 && !push1) ovf1 <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_rr_mux_l2.sv
// tb_arb_rr_mux_l2
// Self-checking bench for arb_rr_mux_l2. A queue-based model of the two
// lanes tracks the expected outputs; a compare process checks the DUT on
// every falling edge, and directed sequences add literal expectations.
module tb_arb_rr_mux_l2;

  logic       clk;
  logic       reset_L;
  logic       valid0, valid1, ready_out;
  logic [7:0] data_in0, data_in1;
  logic       full0, full1, ovf0, ovf1, selectorL2, validout;
  logic [7:0] dataout;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  // Behavioural model state
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         m_last;
  bit         m_valid, m_sel, m_ovf0, m_ovf1;
  logic [7:0] m_data;

  arb_rr_mux_l2 #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .valid0        (valid0),
    .data_in0_muxL2(data_in0),
    .valid1        (valid1),
    .data_in1_muxL2(data_in1),
    .ready_out     (ready_out),
    .full0         (full0),
    .full1         (full1),
    .ovf0          (ovf0),
    .ovf1          (ovf1),
    .selectorL2    (selectorL2),
    .validout      (validout),
    .dataout_muxL2 (dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOne(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    q0.delete();
    q1.delete();
    m_last  = 1;
    m_valid = 0;
    m_sel   = 0;
    m_data  = 8'h00;
    m_ovf0  = 0;
    m_ovf1  = 0;
  endtask

  // One rising edge of the model: grant from stored words, then accept pushes
  task automatic modelEdge();
    int lane;
    if (ready_out && (q0.size() > 0 || q1.size() > 0)) begin
      if (q0.size() > 0 && q1.size() > 0) lane = (m_last == 0) ? 1 : 0;
      else                                lane = (q0.size() > 0) ? 0 : 1;
      if (lane == 0) m_data = q0.pop_front();
      else           m_data = q1.pop_front();
      m_sel   = (lane == 1);
      m_valid = 1;
      m_last  = lane;
    end else begin
      m_valid = 0;
    end
    if (valid0) begin
      if (q0.size() < 4) q0.push_back(data_in0);
      else               m_ovf0 = 1;
    end
    if (valid1) begin
      if (q1.size() < 4) q1.push_back(data_in1);
      else               m_ovf1 = 1;
    end
  endtask

  task automatic checkOutput();
    checkOne("validout", int'(validout), int'(m_valid));
    checkOne("dataout", int'(dataout), int'(m_data));
    checkOne("selectorL2", int'(selectorL2), int'(m_sel));
    checkOne("full0", int'(full0), int'(q0.size() == 4));
    checkOne("full1", int'(full1), int'(q1.size() == 4));
    checkOne("ovf0", int'(ovf0), int'(m_ovf0));
    checkOne("ovf1", int'(ovf1), int'(m_ovf1));
  endtask

  // Compare process: outputs are settled on the falling edge
  always @(negedge clk) begin
    if (check_en) checkOutput();
  end

  // Drive one cycle of inputs (called at a falling edge), advance the model
  // on the rising edge and return at the next falling edge.
  task automatic applyStimulus(input bit v0, input logic [7:0] a,
                               input bit v1, input logic [7:0] b, input bit r);
    valid0    = v0;
    data_in0  = a;
    valid1    = v1;
    data_in1  = b;
    ready_out = r;
    @(posedge clk);
    if (reset_L) modelEdge();
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges, released at a falling edge
  task automatic doReset();
    #2;
    reset_L = 1'b0;
    modelReset();
    #1;
    checkOne("rst_validout", int'(validout), 0);
    checkOne("rst_dataout", int'(dataout), 0);
    checkOne("rst_selector", int'(selectorL2), 0);
    checkOne("rst_full", int'({full0, full1}), 0);
    checkOne("rst_ovf", int'({ovf0, ovf1}), 0);
    valid0    = 1'b0;
    valid1    = 1'b0;
    ready_out = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    logic [7:0] w;
    int sent;
    reset_L   = 1'b1;
    valid0    = 1'b0;
    valid1    = 1'b0;
    data_in0  = 8'h00;
    data_in1  = 8'h00;
    ready_out = 1'b0;
    modelReset();
    @(negedge clk);
    doReset();
    check_en = 1;

    // Single lane: A1, A2, A3 out on the three edges after each push
    applyStimulus(1, 8'hA1, 0, 8'h00, 1);
    checkOne("single_idle", int'(validout), 0);
    applyStimulus(1, 8'hA2, 0, 8'h00, 1);
    checkOne("single_d0", int'(dataout), 8'hA1);
    checkOne("single_sel0", int'(selectorL2), 0);
    applyStimulus(1, 8'hA3, 0, 8'h00, 1);
    checkOne("single_d1", int'(dataout), 8'hA2);
    applyStimulus(0, 8'h00, 0, 8'h00, 1);
    checkOne("single_d2", int'(dataout), 8'hA3);
    checkOne("single_v2", int'(validout), 1);
    applyStimulus(0, 8'h00, 0, 8'h00, 1);
    checkOne("single_done", int'(validout), 0);
    checkOne("single_hold", int'(dataout), 8'hA3);

    // Contention from a fresh reset: 10, 20, 11, 21
    doReset();
    applyStimulus(1, 8'h10, 1, 8'h20, 0);
    applyStimulus(1, 8'h11, 1, 8'h21, 0);
    applyStimulus(0, 8'h00, 0, 8'h00, 1);
    checkOne("cont_d0", int'({selectorL2, dataout}), 9'h010);
    applyStimulus(0, 8'h00, 0, 8'h00, 1);
    checkOne("cont_d1", int'({selectorL2, dataout}), 9'h120);
    applyStimulus(0, 8'h00, 0, 8'h00, 1);
    checkOne("cont_d2", int'({selectorL2, dataout}), 9'h011);
    applyStimulus(0, 8'h00, 0, 8'h00, 1);
    checkOne("cont_d3", int'({selectorL2, dataout}), 9'h121);
    applyStimulus(0, 8'h00, 0, 8'h00, 1);

    // Backpressure on lane 1, then drain in order
    doReset();
    for (int i = 0; i < 4; i++) begin
      w = 8'h30 + 8'(i);
      applyStimulus(0, 8'h00, 1, w, 0);
    end
    checkOne("bp_full1", int'(full1), 1);
    applyStimulus(0, 8'h00, 0, 8'h00, 0);
    checkOne("bp_novalid", int'(validout), 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 8'h00, 0, 8'h00, 1);
      checkOne("bp_drain", int'(dataout), 8'h30 + i);
    end
    applyStimulus(0, 8'h00, 0, 8'h00, 1);

    // Overflow: push while full and popping is accepted; push while stalled drops
    doReset();
    for (int i = 0; i < 4; i++) begin
      w = 8'h40 + 8'(i);
      applyStimulus(1, w, 0, 8'h00, 0);
    end
    applyStimulus(1, 8'h66, 0, 8'h00, 1);
    checkOne("ovf_popfull_ovf0", int'(ovf0), 0);
    checkOne("ovf_popfull_full0", int'(full0), 1);
    applyStimulus(1, 8'h55, 0, 8'h00, 0);
    checkOne("ovf_drop", int'(ovf0), 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 8'h00, 0, 8'h00, 1);
    checkOne("ovf_sticky", int'(ovf0), 1);

    // Reset mid-stream: buffered words must not reappear
    doReset();
    applyStimulus(1, 8'h71, 0, 8'h00, 0);
    applyStimulus(1, 8'h72, 0, 8'h00, 0);
    applyStimulus(1, 8'h73, 0, 8'h00, 0);
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 8'h00, 0, 8'h00, 1);
      checkOne("stale_none", int'(validout), 0);
    end

    // Wrap-around: 10 words through lane 1 with random ready_out
    sent = 0;
    for (int c = 0; c < 200 && (sent < 10 || q1.size() > 0); c++) begin
      if (sent < 10 && q1.size() < 4 && $urandom_range(0, 1) == 1) begin
        w = 8'hB0 + 8'(sent);
        applyStimulus(0, 8'h00, 1, w, 1'($urandom_range(0, 1)));
        sent++;
      end else begin
        applyStimulus(0, 8'h00, 0, 8'h00, 1'($urandom_range(0, 1)));
      end
    end
    checkOne("wrap_drained", q1.size() + (10 - sent), 0);

    // Random traffic on both lanes with occasional resets
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) doReset();
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                    1'($urandom_range(0, 1)), 8'($urandom),
                    ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
